fphub_result_stage: RTL and testbench
=====================================

FPHUB_RESULT_STAGE -- requirements
Module: fphub_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the HUB word width (sign + exponent + mantissa).
REQ-002 SHALL have parameter TAG_W, default 1, meaning the width of the sideband tag carried with each result.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port result_i  input  WIDTH  HUB product from the multiplier stage.
REQ-006 SHALL have port tag_i  input  TAG_W  sideband tag accompanying result_i.
REQ-007 SHALL have port in_valid_i  input  1  upstream result valid.
REQ-008 SHALL have port in_ready_o  output  1  stage can accept a result this cycle.
REQ-009 SHALL have port flush_i  input  1  discard all held results.
REQ-010 SHALL have port result_o  output  WIDTH  head-of-queue result.
REQ-011 SHALL have port status_o  output  5  flags {NV,DZ,OF,UF,NX}, MSB first, for the head entry.
REQ-012 SHALL have port tag_o  output  TAG_W  head-of-queue tag.
REQ-013 SHALL have port out_valid_o  output  1  head entry valid.
REQ-014 SHALL have port out_ready_i  input  1  downstream accepts the head entry.
REQ-015 SHALL have port occupancy_o  output  2  number of held entries (0..2).

Function
REQ-016 SHALL implement a 2-entry in-order FIFO of {result, tag, status}.
REQ-017 SHALL push on a rising edge when in_valid_i && in_ready_o && !flush_i.
REQ-018 SHALL pop on a rising edge when out_valid_o && out_ready_i && !flush_i.
REQ-019 SHALL drive in_ready_o = (occupancy_o != 2), purely from registered state, with no combinational path from out_ready_i.
REQ-020 SHALL drive out_valid_o = (occupancy_o != 0), so latency from push to out_valid_o is exactly 1 cycle.
REQ-021 SHALL, on a simultaneous push and pop at occupancy 1, keep occupancy at 1 and present the new entry on the next cycle.
REQ-022 SHALL keep result_o, tag_o and status_o stable while out_valid_o && !out_ready_i.
REQ-023 SHALL treat read/write pointers as 1-bit values wrapping modulo 2.
REQ-024 SHALL, on flush_i=1, set occupancy to 0 on the next edge; flush overrides a same-cycle push and pop.
REQ-025 SHALL drive result_o, tag_o and status_o to 0 when occupancy_o == 0.
REQ-026 SHALL compute status at push time from result_i: OF = result_i[WIDTH-2:0] all ones; UF = result_i[WIDTH-2:0] all zeros; NV = DZ = NX = 0.

Reset
REQ-027 SHALL, while rst_ni=0, asynchronously clear pointers and occupancy.
REQ-028 SHALL, while rst_ni=0, hold occupancy_o=0, out_valid_o=0, in_ready_o=1, and result_o, tag_o and status_o at 0.
REQ-029 SHALL, on reset asserted mid-operation, lose all held entries, with no output pulse after release.

Configuration
REQ-030 SHALL, with FPHUB_RESULT_STATUS_EN defined, compute and store status per REQ-026.
REQ-031 SHALL, without FPHUB_RESULT_STATUS_EN, drive status_o constant 0 and omit the status storage; all other behaviour is unchanged.

Verification
REQ-032 SHALL cover single transfer: push 16'h3C00 with tag 1, out_ready_i=1 -> next cycle out_valid_o=1, result_o=16'h3C00, tag_o=1, status_o=5'b0; the cycle after, occupancy_o=0.
REQ-033 SHALL cover backpressure: out_ready_i=0, push 16'h4000 then 16'h4200 -> occupancy_o=2, in_ready_o=0, result_o held at 16'h4000; out_ready_i=1 -> 16'h4000 then 16'h4200 pop in order.
REQ-034 SHALL cover flags with the macro defined: push 16'h7FFF -> status_o=5'b00100 (OF); push 16'h8000 -> status_o=5'b00010 (UF); without the macro, both give 5'b0.
REQ-035 SHALL cover simultaneous events: occupancy 1 holding 16'h1111, push 16'h2222 and pop in the same cycle -> occupancy_o stays 1 and result_o=16'h2222.
REQ-036 SHALL cover flush: occupancy 2 with flush_i=1 and in_valid_i=1 in the same cycle -> next cycle occupancy_o=0, out_valid_o=0, in_ready_o=1, and the pushed value is dropped.
REQ-037 SHALL cover mid-operation reset: occupancy 2, rst_ni low for 1 cycle -> immediately out_valid_o=0, and no stale entry appears after release.

Source files
------------

// File: rtl/fphub_result_stage.sv
// fphub_result_stage: 2-entry in-order result FIFO that sits after the HUB
// multiplier. Each entry holds {result, tag, status}.
//
// Handshake: a transfer happens on a rising edge when valid && ready are both
// high. in_ready_o depends only on registered occupancy (no path from
// out_ready_i), and out_valid_o is high whenever an entry is held. flush_i
// suppresses both push and pop in the cycle it is high and empties the queue.
//
// Optional macro FPHUB_RESULT_STATUS_EN: when defined, overflow/underflow flags
// are computed at push time and stored with each entry; when undefined,
// status_o is constant 0 and no status storage is built.
module fphub_result_stage #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] result_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       status_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       occupancy_o
);

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] res_mem_q [2];
  logic [WIDTH-1:0] res_mem_d [2];
  logic [TAG_W-1:0] tag_mem_q [2];
  logic [TAG_W-1:0] tag_mem_d [2];
  logic             push;
  logic             pop;
  logic             not_empty;

  assign not_empty   = (occ_q != 2'd0);
  assign in_ready_o  = (occ_q != 2'd2);
  assign out_valid_o = not_empty;
  assign occupancy_o = occ_q;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  // Next-state for pointers, occupancy and payload storage.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    res_mem_d = res_mem_q;
    tag_mem_d = tag_mem_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (push) begin
        res_mem_d[wr_ptr_q] = result_i;
        tag_mem_d[wr_ptr_q] = tag_i;
        wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers; reset empties the queue and clears the payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        res_mem_q[i] <= '0;
        tag_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      res_mem_q <= res_mem_d;
      tag_mem_q <= tag_mem_d;
    end
  end

  // Head entry is presented only when valid; otherwise outputs read as zero.
  always_comb begin
    result_o = '0;
    tag_o    = '0;
    if (not_empty) begin
      result_o = res_mem_q[rd_ptr_q];
      tag_o    = tag_mem_q[rd_ptr_q];
    end
  end

`ifdef FPHUB_RESULT_STATUS_EN
  logic [4:0] st_mem_q [2];
  logic [4:0] st_mem_d [2];
  logic [4:0] st_new;
  logic       of_flag;
  logic       uf_flag;

  // OF: magnitude field saturated to all ones; UF: magnitude field all zeros.
  // NV, DZ and NX are never raised by this stage.
  always_comb begin
    of_flag = &result_i[WIDTH-2:0];
    uf_flag = ~|result_i[WIDTH-2:0];
    st_new  = {1'b0, 1'b0, of_flag, uf_flag, 1'b0};
  end

  // Status storage follows the same write pointer as the payload.
  always_comb begin
    st_mem_d = st_mem_q;
    if (push) begin
      st_mem_d[wr_ptr_q] = st_new;
    end
  end

  // Status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        st_mem_q[i] <= '0;
      end
    end else begin
      st_mem_q <= st_mem_d;
    end
  end

  // Head status, zero when empty.
  always_comb begin
    status_o = '0;
    if (not_empty) begin
      status_o = st_mem_q[rd_ptr_q];
    end
  end
`else
  assign status_o = 5'b0;
`endif

endmodule

// File: tb/tb_fphub_result_stage.sv
// Testbench for fphub_result_stage: directed scenarios with literal
// expectations plus randomized traffic, all checked against a queue model.
module tb_fphub_result_stage;

  localparam int WIDTH = 16;
  localparam int TAG_W = 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] result_i;
  logic [TAG_W-1:0] tag_i;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] result_o;
  logic [4:0]       status_o;
  logic [TAG_W-1:0] tag_o;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       occupancy;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: the queue contents as seen by the downstream consumer.
  logic [WIDTH-1:0] exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  logic [4:0]       exp_st_q[$];

  fphub_result_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .result_i    (result_i),
    .tag_i       (tag_i),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .result_o    (result_o),
    .status_o    (status_o),
    .tag_o       (tag_o),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .occupancy_o (occupancy)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model_status(input logic [WIDTH-1:0] r);
`ifdef FPHUB_RESULT_STATUS_EN
    logic [4:0] s;
    s = 5'b0;
    if (r[WIDTH-2:0] == {(WIDTH-1){1'b1}}) s[2] = 1'b1;
    if (r[WIDTH-2:0] == {(WIDTH-1){1'b0}}) s[1] = 1'b1;
    return s;
`else
    return 5'b0;
`endif
  endfunction

  function automatic logic [4:0] exp_flag(input logic [4:0] when_enabled);
`ifdef FPHUB_RESULT_STATUS_EN
    return when_enabled;
`else
    return 5'b0 & when_enabled;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge, decided from the model's own fill level.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_tag_q.delete();
      exp_st_q.delete();
    end else if (flush) begin
      exp_q.delete();
      exp_tag_q.delete();
      exp_st_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (exp_q.size() < 2);
      do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop) begin
        void'(exp_q.pop_front());
        void'(exp_tag_q.pop_front());
        void'(exp_st_q.pop_front());
      end
      if (do_push) begin
        exp_q.push_back(result_i);
        exp_tag_q.push_back(tag_i);
        exp_st_q.push_back(model_status(result_i));
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    int n;
    n = exp_q.size();
    check("occupancy", 32'(occupancy), 32'(n));
    check("out_valid", 32'(out_valid), 32'(n != 0));
    check("in_ready",  32'(in_ready),  32'(n != 2));
    check("result",    32'(result_o),  (n != 0) ? 32'(exp_q[0])     : 32'd0);
    check("tag",       32'(tag_o),     (n != 0) ? 32'(exp_tag_q[0]) : 32'd0);
    check("status",    32'(status_o),  (n != 0) ? 32'(exp_st_q[0])  : 32'd0);
  end

  // Driver: apply inputs, let one edge pass, return shortly after it.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t,
                      input logic ordy, input logic fl);
    in_valid  = v;
    result_i  = d;
    tag_i     = t;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    result_i  = '0;
    tag_i     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_occ",   32'(occupancy), 32'd0);
    check("rst_res",   32'(result_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single transfer.
    step(1, 16'h3C00, 1'b1, 1'b1, 0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_res",   32'(result_o), 32'h3C00);
    check("single_tag",   32'(tag_o), 32'd1);
    check("single_st",    32'(status_o), 32'd0);
    step(0, 16'h0, 1'b0, 1'b1, 0);
    check("single_drain", 32'(occupancy), 32'd0);

    // Backpressure and in-order drain.
    step(1, 16'h4000, 1'b0, 1'b0, 0);
    step(1, 16'h4200, 1'b1, 1'b0, 0);
    check("bp_occ",   32'(occupancy), 32'd2);
    check("bp_ready", 32'(in_ready), 32'd0);
    check("bp_res",   32'(result_o), 32'h4000);
    step(1, 16'h4400, 1'b0, 1'b0, 0);
    check("bp_hold",  32'(result_o), 32'h4000);
    step(0, 16'h0, 1'b0, 1'b1, 0);
    check("bp_pop1",  32'(result_o), 32'h4200);
    check("bp_tag1",  32'(tag_o), 32'd1);
    step(0, 16'h0, 1'b0, 1'b1, 0);
    check("bp_empty", 32'(occupancy), 32'd0);

    // Flags; second push overlaps a pop at occupancy 1.
    step(1, 16'h7FFF, 1'b0, 1'b0, 0);
    check("flag_of", 32'(status_o), 32'(exp_flag(5'b00100)));
    step(1, 16'h8000, 1'b0, 1'b1, 0);
    check("flag_uf", 32'(status_o), 32'(exp_flag(5'b00010)));
    check("flag_uf_res", 32'(result_o), 32'h8000);
    step(0, 16'h0, 1'b0, 1'b1, 0);

    // Simultaneous push and pop at occupancy 1.
    step(1, 16'h1111, 1'b0, 1'b0, 0);
    check("sim_pre", 32'(result_o), 32'h1111);
    step(1, 16'h2222, 1'b1, 1'b1, 0);
    check("sim_occ", 32'(occupancy), 32'd1);
    check("sim_res", 32'(result_o), 32'h2222);
    step(0, 16'h0, 1'b0, 1'b1, 0);

    // Flush at full with a concurrent push attempt.
    step(1, 16'hAAAA, 1'b0, 1'b0, 0);
    step(1, 16'hBBBB, 1'b1, 1'b0, 0);
    step(1, 16'h5555, 1'b1, 1'b1, 1);
    check("fl_occ",   32'(occupancy), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    step(0, 16'h0, 1'b0, 1'b1, 0);
    check("fl_drop",  32'(out_valid), 32'd0);

    // Reset asserted while full.
    step(1, 16'hC0DE, 1'b0, 1'b0, 0);
    step(1, 16'hBEEF, 1'b1, 1'b0, 0);
    check("mr_full", 32'(occupancy), 32'd2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_occ",   32'(occupancy), 32'd0);
    check("mr_res",   32'(result_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 16'h0, 1'b0, 1'b1, 0);
    check("mr_stale", 32'(out_valid), 32'd0);
    step(0, 16'h0, 1'b0, 1'b1, 0);
    check("mr_stale2", 32'(out_valid), 32'd0);

    // Randomized traffic; corner values appear often to exercise the flags.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] d;
      case ($urandom_range(0, 5))
        0: d = 16'h7FFF;
        1: d = 16'hFFFF;
        2: d = 16'h0000;
        3: d = 16'h8000;
        default: d = WIDTH'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), d, TAG_W'($urandom), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 29) == 0));
    end
    step(0, 16'h0, 1'b0, 1'b1, 0);
    step(0, 16'h0, 1'b0, 1'b1, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
